// File: rtl/bg_gen_if.sv
// Pixel-stream bundle between the VGA timing/driver side and the background generator.
// The master drives coordinates, frame pulse and mode request; the slave returns the registered colour.
interface bg_gen_if #(
    parameter int COORD_W = 11,
    parameter int COLOR_W = 4
);
    logic               startOfFrame;
    logic [COORD_W-1:0] pxl_x;
    logic [COORD_W-1:0] pxl_y;
    logic [2:0]         screen;
    logic [COLOR_W-1:0] bg_red;
    logic [COLOR_W-1:0] bg_green;
    logic [COLOR_W-1:0] bg_blue;
    logic               bg_valid;

    modport master (
        output startOfFrame, pxl_x, pxl_y, screen,
        input  bg_red, bg_green, bg_blue, bg_valid
    );

    modport slave (
        input  startOfFrame, pxl_x, pxl_y, screen,
        output bg_red, bg_green, bg_blue, bg_valid
    );
endinterface

// File: rtl/bg_gen.sv
// Multi-mode background generator: solid, stripes, checker, gradient, scrolling stripes, starfield.
// One-cycle registered output; mode is latched and scroll advances on each startOfFrame.
module bg_gen #(
    parameter int                 COORD_W     = 11,
    parameter int                 COLOR_W     = 4,
    parameter int                 H_ACTIVE    = 640,
    parameter int                 V_ACTIVE    = 480,
    parameter int                 TILE_LOG2   = 5,
    parameter int                 GRAD_SHIFT  = 6,
    parameter int                 SCROLL_STEP = 2,
    parameter logic [3*COLOR_W-1:0] COLOR_A   = 12'hFFF,
    parameter logic [3*COLOR_W-1:0] COLOR_B   = 12'h000,
    parameter logic [15:0]        LFSR_SEED   = 16'hACE1
) (
    input logic     clk,
    input logic     resetN,
    bg_gen_if.slave bus
);
    localparam int RGB_W = 3 * COLOR_W;

    logic [2:0]         r_mode;
    logic [COORD_W-1:0] r_scroll;
    logic [15:0]        r_lfsr;
    logic [RGB_W-1:0]   r_rgb;
    logic               r_valid;

    logic [2:0]         w_mode;
    logic               w_active;
    logic [15:0]        w_lfsr_next;
    logic               w_scroll_bit;
    logic [COLOR_W-1:0] w_grad_r;
    logic [COLOR_W-1:0] w_grad_g;
    logic [RGB_W-1:0]   w_rgb;

    assign w_mode   = bus.startOfFrame ? bus.screen : r_mode;
    assign w_active = (bus.pxl_x < COORD_W'(H_ACTIVE)) && (bus.pxl_y < COORD_W'(V_ACTIVE));

    // Galois form of x^16+x^14+x^13+x^11, shifting right.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    // Sum stays COORD_W bits wide so the carry out of the scroll add is dropped.
    assign w_scroll_bit = 1'((COORD_W'(bus.pxl_x + r_scroll)) >> TILE_LOG2);
    assign w_grad_r     = COLOR_W'(bus.pxl_x >> GRAD_SHIFT);
    assign w_grad_g     = COLOR_W'(bus.pxl_y >> GRAD_SHIFT);

    always_comb begin
        w_rgb = '0;
        if (w_active) begin
            case (w_mode)
                3'd0: w_rgb = '1;
                3'd1: w_rgb = COLOR_A;
                3'd2: w_rgb = bus.pxl_y[TILE_LOG2] ? COLOR_B : COLOR_A;
                3'd3: w_rgb = bus.pxl_x[TILE_LOG2] ? COLOR_B : COLOR_A;
                3'd4: w_rgb = (bus.pxl_x[TILE_LOG2] ^ bus.pxl_y[TILE_LOG2]) ? COLOR_B : COLOR_A;
                3'd5: w_rgb = {w_grad_r, w_grad_g, {COLOR_W{1'b1}}};
                3'd6: w_rgb = w_scroll_bit ? COLOR_B : COLOR_A;
                3'd7: w_rgb = (r_lfsr[7:0] == 8'h00) ? COLOR_A : COLOR_B;
                default: w_rgb = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_mode   <= 3'd0;
            r_scroll <= '0;
            r_lfsr   <= LFSR_SEED;
            r_rgb    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_rgb   <= w_rgb;
            r_valid <= w_active;
            // Frame start reloads the LFSR ahead of any advance so every frame repeats its stars.
            if (bus.startOfFrame) begin
                r_mode   <= bus.screen;
                r_scroll <= r_scroll + COORD_W'(SCROLL_STEP);
                r_lfsr   <= LFSR_SEED;
            end else if (w_active) begin
                r_lfsr <= w_lfsr_next;
            end
        end
    end

    assign bus.bg_red   = r_rgb[3*COLOR_W-1:2*COLOR_W];
    assign bus.bg_green = r_rgb[2*COLOR_W-1:COLOR_W];
    assign bus.bg_blue  = r_rgb[COLOR_W-1:0];
    assign bus.bg_valid = r_valid;
endmodule

// File: tb/tb_bg_gen.sv
// Directed bench for bg_gen: reset state, mode latching, checker, scrolling, starfield repeat, gradient and async reset.
module tb_bg_gen;
    logic clk;
    logic resetN;
    int   n_checks;
    int   n_errors;

    bg_gen_if #(.COORD_W(11), .COLOR_W(4)) bus ();

    bg_gen dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one pixel, clock it, and leave outputs ready to sample 1 ns after the edge.
    task automatic pix(input logic sof, input int x, input int y, input logic [2:0] scr);
        bus.startOfFrame = sof;
        bus.pxl_x        = 11'(x);
        bus.pxl_y        = 11'(y);
        bus.screen       = scr;
        @(posedge clk);
        #1;
        bus.startOfFrame = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic lsb;
        lsb = v[0];
        v = v >> 1;
        if (lsb) v = v ^ 16'hB400;
        return v;
    endfunction

    task automatic test_reset;
        logic [12:0] got;
        resetN = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.pxl_x = '0;
        bus.pxl_y = '0;
        bus.screen = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        got = {bus.bg_valid, bus.bg_red, bus.bg_green, bus.bg_blue};
        n_checks++;
        if (got !== 13'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected %h", got, 13'h0);
        end
        resetN = 1'b1;
    endtask

    task automatic test_default_mode;
        logic [12:0] got;
        test_reset();
        for (int x = 0; x < 64; x++) begin
            pix(1'b0, x, 10, 3'd3);
            got = {bus.bg_valid, bus.bg_red, bus.bg_green, bus.bg_blue};
            n_checks++;
            if (got !== 13'h1FFF) begin
                n_errors++;
                $display("FAIL default_mode x=%0d: got %h expected %h", x, got, 13'h1FFF);
            end
        end
    endtask

    task automatic test_mode_latch;
        logic [11:0] got;
        logic [11:0] exp_v[5];
        int          xs[5];
        int          ys[5];
        logic        sofs[5];
        logic [2:0]  scrs[5];
        exp_v = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF};
        xs    = '{0, 31, 32, 32, 0};
        ys    = '{0, 0, 0, 32, 32};
        sofs  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        scrs  = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd4};
        for (int i = 0; i < 5; i++) begin
            pix(sofs[i], xs[i], ys[i], scrs[i]);
            got = {bus.bg_red, bus.bg_green, bus.bg_blue};
            n_checks++;
            if (got !== exp_v[i]) begin
                n_errors++;
                $display("FAIL mode_latch step %0d (%0d,%0d): got %h expected %h", i, xs[i], ys[i], got, exp_v[i]);
            end
        end
    endtask

    task automatic test_checker;
        logic [12:0] got;
        logic [12:0] exp_v[6];
        int          xs[6];
        int          ys[6];
        exp_v = '{13'h1FFF, 13'h1000, 13'h1FFF, 13'h0000, 13'h0000, 13'h1000};
        xs    = '{0, 32, 32, 640, 5, 639};
        ys    = '{0, 0, 32, 5, 480, 479};
        for (int i = 0; i < 6; i++) begin
            pix(i == 0, xs[i], ys[i], 3'd4);
            got = {bus.bg_valid, bus.bg_red, bus.bg_green, bus.bg_blue};
            n_checks++;
            if (got !== exp_v[i]) begin
                n_errors++;
                $display("FAIL checker (%0d,%0d): got %h expected %h", xs[i], ys[i], got, exp_v[i]);
            end
        end
    endtask

    task automatic test_scroll;
        logic [11:0] got;
        logic [11:0] exp_v[4];
        int          xs[4];
        logic        sofs[4];
        test_reset();
        for (int i = 0; i < 15; i++) pix(1'b1, 700, 0, 3'd6);
        exp_v = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
        xs    = '{1, 2, 0, 0};
        sofs  = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            pix(sofs[i], xs[i], 0, 3'd6);
            got = {bus.bg_red, bus.bg_green, bus.bg_blue};
            n_checks++;
            if (got !== exp_v[i]) begin
                n_errors++;
                $display("FAIL scroll step %0d x=%0d: got %h expected %h", i, xs[i], got, exp_v[i]);
            end
        end
    endtask

    task automatic test_scroll_wrap;
        logic [11:0] got;
        logic [11:0] exp_v[3];
        int          xs[3];
        test_reset();
        for (int i = 0; i < 1023; i++) pix(1'b1, 700, 0, 3'd6);
        exp_v = '{12'hFFF, 12'h000, 12'h000};
        xs    = '{5, 34, 1};
        for (int i = 0; i < 3; i++) begin
            pix(1'b0, xs[i], 0, 3'd6);
            got = {bus.bg_red, bus.bg_green, bus.bg_blue};
            n_checks++;
            if (got !== exp_v[i]) begin
                n_errors++;
                $display("FAIL scroll_wrap x=%0d: got %h expected %h", xs[i], got, exp_v[i]);
            end
        end
    endtask

    task automatic test_starfield;
        logic [12:0] got;
        logic [12:0] exp_v;
        logic [12:0] ref_frame[650];
        logic [15:0] m;
        for (int f = 0; f < 3; f++) begin
            m = 16'hACE1;
            for (int i = 0; i < 650; i++) begin
                pix(i == 0, i, 0, 3'd7);
                got = {bus.bg_valid, bus.bg_red, bus.bg_green, bus.bg_blue};
                if (f == 1) ref_frame[i] = got;
                if (i >= 1 && i < 640) begin
                    exp_v = (m[7:0] == 8'h00) ? 13'h1FFF : 13'h1000;
                    m = lfsr_step(m);
                end else begin
                    exp_v = 13'h0000;
                end
                if (f >= 1 && i >= 1) begin
                    n_checks++;
                    if (got !== exp_v) begin
                        n_errors++;
                        $display("FAIL starfield frame %0d pixel %0d: got %h expected %h", f, i, got, exp_v);
                    end
                end
                if (f == 2) begin
                    n_checks++;
                    if (got !== ref_frame[i]) begin
                        n_errors++;
                        $display("FAIL star_repeat pixel %0d: got %h expected %h", i, got, ref_frame[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_gradient_reset;
        logic [12:0] got;
        logic [12:0] exp_v[3];
        int          xs[3];
        int          ys[3];
        exp_v = '{13'h100F, 13'h197F, 13'h113F};
        xs    = '{0, 639, 100};
        ys    = '{0, 479, 200};
        for (int i = 0; i < 3; i++) begin
            pix(i == 0, xs[i], ys[i], 3'd5);
            got = {bus.bg_valid, bus.bg_red, bus.bg_green, bus.bg_blue};
            n_checks++;
            if (got !== exp_v[i]) begin
                n_errors++;
                $display("FAIL gradient (%0d,%0d): got %h expected %h", xs[i], ys[i], got, exp_v[i]);
            end
        end
        #2;
        resetN = 1'b0;
        #1;
        got = {bus.bg_valid, bus.bg_red, bus.bg_green, bus.bg_blue};
        n_checks++;
        if (got !== 13'h0) begin
            n_errors++;
            $display("FAIL async_reset: got %h expected %h", got, 13'h0);
        end
        @(posedge clk);
        #1;
        resetN = 1'b1;
        pix(1'b0, 10, 10, 3'd5);
        got = {bus.bg_valid, bus.bg_red, bus.bg_green, bus.bg_blue};
        n_checks++;
        if (got !== 13'h1FFF) begin
            n_errors++;
            $display("FAIL post_reset_mode0: got %h expected %h", got, 13'h1FFF);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_default_mode();
        test_mode_latch();
        test_checker();
        test_scroll();
        test_scroll_wrap();
        test_starfield();
        test_gradient_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
